// File: rtl/monitor_ddr_writer_if.sv
// ============================================================================
//  Module      : monitor_ddr_writer_if
//  Description : Record stream, start/finish control handshake and AXI4
//                write-channel bundle for monitor_ddr_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface monitor_ddr_writer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Record stream from the datapath
  logic [DATA_W-1:0]   rec_data;
  logic                rec_valid;
  logic                rec_ready;
  // Controller handshake
  logic                ddr_write_start;
  logic                ddr_write_start_valid;
  logic                ddr_write_start_ready;
  logic                odd_even_flag;
  logic                ddr_write_finish;
  logic                ddr_write_finish_valid;
  logic                ddr_write_finish_ready;
  // AXI4 write address channel
  logic                M_AXI_AWID;
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [7:0]          M_AXI_AWLEN;
  logic [2:0]          M_AXI_AWSIZE;
  logic [1:0]          M_AXI_AWBURST;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  // AXI4 write data channel
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WLAST;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  // AXI4 write response channel
  logic                M_AXI_BID;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;

  // Writer side: consumes records and control, drives the AXI master
  modport master (
    input  rec_data, rec_valid,
    output rec_ready,
    input  ddr_write_start, ddr_write_start_valid, odd_even_flag,
    output ddr_write_start_ready,
    output ddr_write_finish, ddr_write_finish_valid,
    input  ddr_write_finish_ready,
    output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE,
    output M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  // Environment side: producer, controller and AXI slave
  modport slave (
    output rec_data, rec_valid,
    input  rec_ready,
    output ddr_write_start, ddr_write_start_valid, odd_even_flag,
    input  ddr_write_start_ready,
    input  ddr_write_finish, ddr_write_finish_valid,
    output ddr_write_finish_ready,
    input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE,
    input  M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );
endinterface

`default_nettype wire

// File: rtl/monitor_ddr_writer.sv
// ============================================================================
//  Module      : monitor_ddr_writer
//  Description : Buffers 32-bit monitor records in a FWFT FIFO and writes a
//                full ping-pong region to DDR as fixed-length AXI4 INCR
//                bursts, one burst outstanding at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module monitor_ddr_writer #(
  parameter int              ADDR_W       = 32,
  parameter int              DATA_W       = 32,
  parameter int              BURST_LEN    = 16,
  parameter logic [ADDR_W-1:0] BASE_EVEN  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] BASE_ODD   = 32'h0010_0000,
  parameter int              REGION_BEATS = 1024
) (
  input  wire logic               clk,
  input  wire logic               aresetn,
  monitor_ddr_writer_if.master    bus
);

  localparam int c_FIFO_DEPTH = 2 * BURST_LEN;
  localparam int c_PTR_W      = $clog2(c_FIFO_DEPTH);
  localparam int c_CNT_W      = c_PTR_W + 1;
  localparam int c_NUM_BURSTS = REGION_BEATS / BURST_LEN;
  localparam int c_BURST_W    = $clog2(c_NUM_BURSTS) + 1;
  localparam int c_WORDS_W    = $clog2(REGION_BEATS) + 1;
  localparam int c_BEAT_W     = $clog2(BURST_LEN) + 1;
  localparam int c_BYTE_SHIFT = $clog2(BURST_LEN) + 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_AW   = 3'd2,
    S_W    = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                 r_state;
  logic [DATA_W-1:0]      r_mem [c_FIFO_DEPTH];
  logic [c_PTR_W-1:0]     r_wr_ptr;
  logic [c_PTR_W-1:0]     r_rd_ptr;
  logic [c_CNT_W-1:0]     r_count;
  logic                   r_start_ready;
  logic                   r_awvalid;
  logic [ADDR_W-1:0]      r_awaddr;
  logic                   r_wvalid;
  logic                   r_wlast;
  logic                   r_bready;
  logic                   r_fin_valid;
  logic                   r_finish;
  logic                   r_odd;
  logic                   r_err;
  logic [c_BURST_W-1:0]   r_burst;
  logic [c_WORDS_W-1:0]   r_words;
  logic [c_BEAT_W-1:0]    r_beat;

  logic                   w_rec_ready;
  logic                   w_push;
  logic                   w_pop;
  logic [ADDR_W-1:0]      w_base;
  logic [ADDR_W-1:0]      w_burst_addr;

  // Records are only taken while a region is being filled and room remains
  assign w_rec_ready = (r_state != S_IDLE) && (r_state != S_DONE) &&
                       (r_count != c_CNT_W'(c_FIFO_DEPTH)) &&
                       (r_words < c_WORDS_W'(REGION_BEATS));
  assign w_push = bus.rec_valid & w_rec_ready;
  assign w_pop  = r_wvalid & bus.M_AXI_WREADY;

  assign w_base       = r_odd ? BASE_ODD : BASE_EVEN;
  assign w_burst_addr = w_base + (ADDR_W'(r_burst) << c_BYTE_SHIFT);

  assign bus.rec_ready              = w_rec_ready;
  assign bus.ddr_write_start_ready  = r_start_ready;
  assign bus.ddr_write_finish       = r_finish;
  assign bus.ddr_write_finish_valid = r_fin_valid;
  assign bus.M_AXI_AWID             = 1'b0;
  assign bus.M_AXI_AWADDR           = r_awaddr;
  assign bus.M_AXI_AWLEN            = 8'(BURST_LEN - 1);
  assign bus.M_AXI_AWSIZE           = 3'b010;
  assign bus.M_AXI_AWBURST          = 2'b01;
  assign bus.M_AXI_AWVALID          = r_awvalid;
  // Head is gated so WDATA reads as zero whenever no beat is offered
  assign bus.M_AXI_WDATA            = r_wvalid ? r_mem[r_rd_ptr] : '0;
  assign bus.M_AXI_WSTRB            = '1;
  assign bus.M_AXI_WLAST            = r_wlast;
  assign bus.M_AXI_WVALID           = r_wvalid;
  assign bus.M_AXI_BREADY           = r_bready;

  // FIFO storage: no reset needed, occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.rec_data;
  end

  // FIFO pointers and occupancy; reset flushes the buffer
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Control FSM with registered handshake and AXI outputs
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_start_ready <= 1'b0;
      r_awvalid     <= 1'b0;
      r_awaddr      <= '0;
      r_wvalid      <= 1'b0;
      r_wlast       <= 1'b0;
      r_bready      <= 1'b0;
      r_fin_valid   <= 1'b0;
      r_finish      <= 1'b0;
      r_odd         <= 1'b0;
      r_err         <= 1'b0;
      r_burst       <= '0;
      r_words       <= '0;
      r_beat        <= '0;
    end else begin
      if (w_push) r_words <= r_words + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_start_ready <= 1'b1;
          // A start whose payload is 0 is consumed but leaves us idle
          if (bus.ddr_write_start_valid && r_start_ready && bus.ddr_write_start) begin
            r_odd         <= bus.odd_even_flag;
            r_burst       <= '0;
            r_words       <= '0;
            r_err         <= 1'b0;
            r_start_ready <= 1'b0;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Only issue the address once the whole burst is buffered
          if (r_count >= c_CNT_W'(BURST_LEN)) begin
            r_awvalid <= 1'b1;
            r_awaddr  <= w_burst_addr;
            r_state   <= S_AW;
          end
        end
        S_AW: begin
          if (bus.M_AXI_AWREADY) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wlast   <= (BURST_LEN == 1);
            r_beat    <= '0;
            r_state   <= S_W;
          end
        end
        S_W: begin
          if (bus.M_AXI_WREADY) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_B;
            end else begin
              r_beat  <= r_beat + 1'b1;
              r_wlast <= (32'(r_beat) + 32'd2 == 32'(BURST_LEN));
            end
          end
        end
        S_B: begin
          if (bus.M_AXI_BVALID) begin
            r_bready <= 1'b0;
            r_burst  <= r_burst + 1'b1;
            if (bus.M_AXI_BRESP != 2'b00) r_err <= 1'b1;
            if (r_burst == c_BURST_W'(c_NUM_BURSTS - 1)) begin
              r_fin_valid <= 1'b1;
              r_finish    <= ~(r_err | (bus.M_AXI_BRESP != 2'b00));
              r_state     <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          if (bus.ddr_write_finish_ready) begin
            r_fin_valid   <= 1'b0;
            r_finish      <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_monitor_ddr_writer.sv
// ============================================================================
//  Module      : tb_monitor_ddr_writer
//  Description : Self-checking bench for monitor_ddr_writer: record producer,
//                AXI4 write slave with optional backpressure, data scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_monitor_ddr_writer;

  localparam int          BL   = 16;
  localparam int          NB   = 64;
  localparam int          RB   = 1024;
  localparam logic [31:0] BEVN = 32'h0000_0000;
  localparam logic [31:0] BODD = 32'h0010_0000;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  monitor_ddr_writer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  monitor_ddr_writer #(
    .ADDR_W(32), .DATA_W(32), .BURST_LEN(BL),
    .BASE_EVEN(BEVN), .BASE_ODD(BODD), .REGION_BEATS(RB)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Environment controls and state
  int          feed_limit = 0, feed_cnt = 0;
  int          aw_pct = 100, w_pct = 100, rec_pct = 100, err_burst = -1;
  logic [31:0] data_base = '0, exp_base = '0;
  bit          flush = 1'b1;
  int          aw_cnt = 0, wb_cnt = 0, b_idx = 0, b_pend = 0, beat = 0, cyc = 0;
  bit          rec_acc = 1'b0, b_acc = 1'b0;
  bit          aw_stall = 1'b0, w_stall = 1'b0;
  logic [31:0] s_awaddr, s_wdata, cur_addr;
  logic        s_wlast;
  logic [31:0] exp_q [$];
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Producer + AXI slave: drive at negedge, sample handshakes 1ns later
  always @(negedge clk) begin
    cyc++;
    if (flush) begin
      bus.rec_valid = 1'b0; rec_acc = 1'b0;
      bus.M_AXI_BVALID = 1'b0; b_acc = 1'b0; b_pend = 0;
      exp_q.delete(); beat = 0; aw_stall = 1'b0; w_stall = 1'b0;
    end else begin
      if (rec_acc) begin bus.rec_valid = 1'b0; rec_acc = 1'b0; end
      if (!bus.rec_valid && feed_cnt < feed_limit && $urandom_range(0, 99) < rec_pct) begin
        bus.rec_valid = 1'b1;
        bus.rec_data  = data_base + feed_cnt;
      end
      bus.M_AXI_AWREADY = ($urandom_range(0, 99) < aw_pct);
      bus.M_AXI_WREADY  = ($urandom_range(0, 99) < w_pct);
      if (b_acc) begin bus.M_AXI_BVALID = 1'b0; b_acc = 1'b0; end
      if (!bus.M_AXI_BVALID && b_pend > 0) begin
        bus.M_AXI_BVALID = 1'b1;
        bus.M_AXI_BRESP  = (b_idx == err_burst) ? 2'b10 : 2'b00;
        b_pend--;
      end
      #1;
      if (aw_stall) begin
        check("aw_stall_valid", bus.M_AXI_AWVALID, 1);
        check("aw_stall_addr", bus.M_AXI_AWADDR, s_awaddr);
      end
      if (w_stall) begin
        check("w_stall_valid", bus.M_AXI_WVALID, 1);
        check("w_stall_data", bus.M_AXI_WDATA, s_wdata);
        check("w_stall_last", bus.M_AXI_WLAST, s_wlast);
      end
      aw_stall = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
      s_awaddr = bus.M_AXI_AWADDR;
      w_stall  = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
      s_wdata  = bus.M_AXI_WDATA;
      s_wlast  = bus.M_AXI_WLAST;
      if (bus.rec_valid && bus.rec_ready) begin
        exp_q.push_back(bus.rec_data);
        feed_cnt++;
        rec_acc = 1'b1;
      end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        check("w_after_aw", aw_cnt > wb_cnt, 1);
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("wdata", bus.M_AXI_WDATA, exp_q.pop_front());
        check("wlast", bus.M_AXI_WLAST, beat == BL - 1);
        mem[cur_addr + 32'(4 * beat)] = bus.M_AXI_WDATA;
        beat++;
        if (beat == BL) begin beat = 0; wb_cnt++; b_pend++; end
      end
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
        check("awaddr", bus.M_AXI_AWADDR, exp_base + 32'(aw_cnt * BL * 4));
        check("awlen", bus.M_AXI_AWLEN, BL - 1);
        cur_addr = bus.M_AXI_AWADDR;
        aw_cnt++;
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
        b_idx++;
        b_acc = 1'b1;
      end
    end
  end

  task automatic prep(input bit flag, input logic [31:0] dbase, input int awp, input int wp,
                      input int rp, input int errb, input int limit);
    aw_cnt = 0; wb_cnt = 0; b_idx = 0; feed_cnt = 0; beat = 0;
    exp_base = flag ? BODD : BEVN;
    data_base = dbase; aw_pct = awp; w_pct = wp; rec_pct = rp;
    err_burst = errb; feed_limit = limit;
  endtask

  task automatic do_start(input bit payload, input bit flag);
    int t = 0;
    @(negedge clk); #2;
    bus.ddr_write_start = payload; bus.odd_even_flag = flag;
    bus.ddr_write_start_valid = 1'b1;
    while (!bus.ddr_write_start_ready && t < 100) begin @(negedge clk); #2; t++; end
    check("start_ready_seen", bus.ddr_write_start_ready, 1);
    @(negedge clk); #2;
    bus.ddr_write_start_valid = 1'b0;
  endtask

  task automatic run_region(input bit flag, input logic [31:0] dbase, input int awp,
                            input int wp, input int rp, input int errb, input bit exp_fin);
    int t = 0;
    prep(flag, dbase, awp, wp, rp, errb, RB);
    do_start(1'b1, flag);
    while (!bus.ddr_write_finish_valid && t < 30000) begin @(negedge clk); #2; t++; end
    check("finish_valid_seen", bus.ddr_write_finish_valid, 1);
    check("finish", bus.ddr_write_finish, exp_fin);
    check("burst_count", aw_cnt, NB);
    check("bresp_count", b_idx, NB);
    check("words_fed", feed_cnt, RB);
    check("sb_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #2;
    check("finish_hold_valid", bus.ddr_write_finish_valid, 1);
    check("finish_hold", bus.ddr_write_finish, exp_fin);
    bus.ddr_write_finish_ready = 1'b1;
    @(negedge clk); #2;
    bus.ddr_write_finish_ready = 1'b0;
    check("finish_valid_drop", bus.ddr_write_finish_valid, 0);
    check("idle_start_ready", bus.ddr_write_start_ready, 1);
  endtask

  // Reset value checks shared by power-up and mid-operation reset
  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, bus.ddr_write_start_ready, 0);
    check({tag, "_rec_ready"}, bus.rec_ready, 0);
    check({tag, "_awvalid"}, bus.M_AXI_AWVALID, 0);
    check({tag, "_awaddr"}, bus.M_AXI_AWADDR, 0);
    check({tag, "_wvalid"}, bus.M_AXI_WVALID, 0);
    check({tag, "_wlast"}, bus.M_AXI_WLAST, 0);
    check({tag, "_wdata"}, bus.M_AXI_WDATA, 0);
    check({tag, "_bready"}, bus.M_AXI_BREADY, 0);
    check({tag, "_fin_valid"}, bus.ddr_write_finish_valid, 0);
    check({tag, "_finish"}, bus.ddr_write_finish, 0);
  endtask

  initial begin
    int t;
    int t_acc;
    bit aw_seen;
    bit rr_ok;
    bus.rec_valid = 1'b0; bus.rec_data = '0;
    bus.ddr_write_start = 1'b0; bus.ddr_write_start_valid = 1'b0;
    bus.odd_even_flag = 1'b0; bus.ddr_write_finish_ready = 1'b0;
    bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
    bus.M_AXI_BID = 1'b0; bus.M_AXI_BRESP = 2'b00; bus.M_AXI_BVALID = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("rst");
    check("rst_awlen", bus.M_AXI_AWLEN, 8'd15);
    check("rst_awsize", bus.M_AXI_AWSIZE, 3'b010);
    check("rst_awburst", bus.M_AXI_AWBURST, 2'b01);
    check("rst_wstrb", bus.M_AXI_WSTRB, 4'hF);
    check("rst_awid", bus.M_AXI_AWID, 0);
    aresetn = 1'b1;
    @(negedge clk); #2;
    flush = 1'b0;

    // Start with payload 0 is consumed and ignored
    do_start(1'b0, 1'b0);
    check("null_start_idle_ready", bus.ddr_write_start_ready, 1);
    check("null_start_rec_ready", bus.rec_ready, 0);

    // Even region, no backpressure
    run_region(1'b0, 32'd0, 100, 100, 100, -1, 1'b1);
    check("mem_first", mem[32'h0000_0000], 32'd0);
    check("mem_last", mem[32'h0000_0FFC], 32'd1023);

    // Odd region, same stream
    run_region(1'b1, 32'd0, 100, 100, 100, -1, 1'b1);
    check("mem_odd_last", mem[32'h0010_0FFC], 32'd1023);

    // Random backpressure on all channels
    run_region(1'b0, 32'h0000_5000, 30, 50, 60, -1, 1'b1);

    // Error response on burst 5
    run_region(1'b1, 32'h0000_A000, 100, 100, 100, 5, 1'b0);

    // Partial burst: 15 words must not trigger an address
    prep(1'b0, 32'h0000_9000, 100, 100, 100, -1, 15);
    do_start(1'b1, 1'b0);
    t = 0;
    while (feed_cnt < 15 && t < 200) begin @(negedge clk); #2; t++; end
    check("partial_fed", feed_cnt, 15);
    aw_seen = 1'b0; rr_ok = 1'b1;
    repeat (20) begin
      @(negedge clk); #2;
      aw_seen |= bus.M_AXI_AWVALID;
      rr_ok &= bus.rec_ready;
    end
    check("partial_no_awvalid", aw_seen, 0);
    check("partial_rec_ready", rr_ok, 1);
    feed_limit = 16;
    t = 0;
    while (feed_cnt < 16 && t < 200) begin @(negedge clk); #2; t++; end
    t_acc = cyc;
    t = 0;
    while (!bus.M_AXI_AWVALID && t < 10) begin @(negedge clk); #2; t++; end
    check("aw_after_16th_valid", bus.M_AXI_AWVALID, 1);
    check("aw_after_16th_latency_le2", (cyc - t_acc) <= 2, 1);

    // Continue the region and reset in the middle of burst 10's data phase
    feed_limit = RB;
    t = 0;
    while (!(aw_cnt == 11 && wb_cnt == 10 && beat >= 4) && t < 5000) begin
      @(negedge clk); #2; t++;
    end
    check("reached_burst10_w", aw_cnt == 11 && wb_cnt == 10 && beat >= 4, 1);
    #1;
    aresetn = 1'b0;
    flush = 1'b1;
    feed_limit = 0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    #3;
    aresetn = 1'b1;
    @(negedge clk); #2;
    flush = 1'b0;
    check("post_rst_no_finish", bus.ddr_write_finish_valid, 0);

    // A fresh start after reset begins again at the region base
    run_region(1'b0, 32'h0000_7000, 100, 100, 100, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
